// File: rtl/arbiter_sink_pkg.sv
// arbiter_sink_pkg: shared state encoding and counter saturation helper
package arbiter_sink_pkg;
   typedef enum logic [2:0] {IDLE, CAPTURE, SERVICE, ACK, RELEASE} state_t;
   function automatic logic [63:0] sat_val(int w);
      return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
   endfunction
endpackage

// File: rtl/arbiter_sink_4ph_if.sv
// arbiter_sink_4ph_if: 4-phase req/sel/ack link between mutex arbiter and sink
interface arbiter_sink_4ph_if;
   logic req_in, sel_in, ack_out;
   modport master(output req_in, sel_in, input ack_out);
   modport slave(input req_in, sel_in, output ack_out);
endinterface

// File: rtl/arbiter_sink_4ph_sync_chain.sv
// sync_chain: multi-flop synchronizer for one asynchronous input bit
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;
   // shift the raw input through the metastability chain
   always_ff @(posedge clk or posedge rst)
      if (rst) ff <= '0;
      else ff <= {ff[STAGES-2:0], d};
   assign q = ff[STAGES-1];
endmodule

// File: rtl/arbiter_sink_4ph.sv
// arbiter_sink_4ph: clocked 4-phase consumer that services and counts arbiter grants
module arbiter_sink_4ph
   import arbiter_sink_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int SERVICE_CYCLES = 4,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   arbiter_sink_4ph_if.slave hs,
   output logic             busy,
   output logic             grant_valid,
   output logic             grant_id,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1,
   output logic             proto_err
);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(sat_val(CNT_W));
   localparam logic [7:0] SVC_LOAD = 8'(SERVICE_CYCLES - 1);
   state_t state;
   logic [7:0] svc;
   logic req_s, sel_s, ack;
   sync_chain #(.STAGES(SYNC_STAGES)) u_req (.clk(clk), .rst(rst), .d(hs.req_in), .q(req_s));
   sync_chain #(.STAGES(SYNC_STAGES)) u_sel (.clk(clk), .rst(rst), .d(hs.sel_in), .q(sel_s));
   assign hs.ack_out = ack;
   assign busy = state != IDLE;
   // handshake FSM: capture winner, hold service window, ack, wait for release
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= IDLE;
         svc         <= '0;
         ack         <= 1'b0;
         grant_valid <= 1'b0;
         grant_id    <= 1'b0;
         grant_cnt0  <= '0;
         grant_cnt1  <= '0;
         proto_err   <= 1'b0;
      end else begin
         grant_valid <= 1'b0;
         case (state)
            IDLE: if (req_s) state <= CAPTURE;
            CAPTURE:
               if (!req_s) begin
                  proto_err <= 1'b1;
                  state     <= IDLE;
               end else begin
                  grant_id <= sel_s;
                  svc      <= SVC_LOAD;
                  state    <= SERVICE;
               end
            SERVICE:
               if (!req_s) begin
                  proto_err <= 1'b1;
                  state     <= IDLE;
               end else if (svc == 8'd0) begin
                  state       <= ACK;
                  ack         <= 1'b1;
                  grant_valid <= 1'b1;
                  if (grant_id) grant_cnt1 <= (grant_cnt1 == CNT_SAT) ? grant_cnt1 : grant_cnt1 + CNT_W'(1);
                  else grant_cnt0 <= (grant_cnt0 == CNT_SAT) ? grant_cnt0 : grant_cnt0 + CNT_W'(1);
               end else svc <= svc - 8'd1;
            ACK:
               if (!req_s) begin
                  ack   <= 1'b0;
                  state <= RELEASE;
               end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_arbiter_sink_4ph.sv
// tb_arbiter_sink_4ph: directed checks of timing, counting, errors and reset
module tb_arbiter_sink_4ph;
   logic clk = 1'b0, rst = 1'b1;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   arbiter_sink_4ph_if a_if(), b_if(), c_if();
   logic busy_a, gv_a, gid_a, pe_a, busy_b, gv_b, gid_b, pe_b, busy_c, gv_c, gid_c, pe_c;
   logic [15:0] c0_a, c1_a, c0_c, c1_c;
   logic [1:0] c0_b, c1_b;
   arbiter_sink_4ph u_a (.clk(clk), .rst(rst), .hs(a_if.slave), .busy(busy_a), .grant_valid(gv_a),
      .grant_id(gid_a), .grant_cnt0(c0_a), .grant_cnt1(c1_a), .proto_err(pe_a));
   arbiter_sink_4ph #(.CNT_W(2)) u_b (.clk(clk), .rst(rst), .hs(b_if.slave), .busy(busy_b),
      .grant_valid(gv_b), .grant_id(gid_b), .grant_cnt0(c0_b), .grant_cnt1(c1_b), .proto_err(pe_b));
   arbiter_sink_4ph #(.SERVICE_CYCLES(1), .SYNC_STAGES(3)) u_c (.clk(clk), .rst(rst), .hs(c_if.slave),
      .busy(busy_c), .grant_valid(gv_c), .grant_id(gid_c), .grant_cnt0(c0_c), .grant_cnt1(c1_c),
      .proto_err(pe_c));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      a_if.req_in = 0; a_if.sel_in = 0;
      b_if.req_in = 0; b_if.sel_in = 0;
      c_if.req_in = 0; c_if.sel_in = 0;
      step(3);
      rst = 0;
      step(1);
      chk("rst_a_ack", {a_if.ack_out, busy_a, gv_a, gid_a, pe_a}, 0);
      chk("rst_a_cnt", {c0_a, c1_a}, 0);
      chk("rst_b", {b_if.ack_out, busy_b, gv_b, gid_b, pe_b, c0_b, c1_b}, 0);
      chk("rst_c", {c_if.ack_out, busy_c, gv_c, gid_c, pe_c}, 0);
      chk("rst_c_cnt", {c0_c, c1_c}, 0);
      // single grant to client 0
      a_if.req_in = 1;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         chk($sformatf("g0_ack_e%0d", k), a_if.ack_out, k == 8);
      end
      chk("g0_valid", gv_a, 1);
      chk("g0_id", gid_a, 0);
      chk("g0_cnt0", c0_a, 1);
      chk("g0_busy", busy_a, 1);
      step(1);
      chk("g0_valid_off", gv_a, 0);
      a_if.req_in = 0;
      for (int k = 1; k <= 3; k++) begin
         step(1);
         chk($sformatf("g0_rel_e%0d", k), a_if.ack_out, k < 3);
      end
      chk("g0_busy_rel", busy_a, 1);
      step(1);
      chk("g0_busy_idle", busy_a, 0);
      // back-to-back grants to client 1
      a_if.sel_in = 1; a_if.req_in = 1;
      step(8);
      chk("b2b_ack1", a_if.ack_out, 1);
      chk("b2b_id", gid_a, 1);
      chk("b2b_cnt1a", c1_a, 1);
      a_if.req_in = 0;
      step(3);
      chk("b2b_ackfall", a_if.ack_out, 0);
      a_if.req_in = 1;
      step(7);
      chk("b2b_ack2_early", a_if.ack_out, 0);
      step(1);
      chk("b2b_ack2", a_if.ack_out, 1);
      chk("b2b_cnt1b", c1_a, 2);
      chk("b2b_cnt0", c0_a, 1);
      a_if.req_in = 0;
      step(4);
      chk("b2b_idle", busy_a, 0);
      // withdraw during service
      a_if.sel_in = 0; a_if.req_in = 1;
      step(4);
      a_if.req_in = 0;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         chk($sformatf("err_ack_e%0d", k), a_if.ack_out, 0);
      end
      chk("err_flag", pe_a, 1);
      chk("err_cnts", {c0_a, c1_a}, {16'd1, 16'd2});
      chk("err_busy", busy_a, 0);
      a_if.req_in = 1;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         chk($sformatf("post_err_ack_e%0d", k), a_if.ack_out, k == 8);
      end
      chk("post_err_cnt0", c0_a, 2);
      chk("post_err_flag", pe_a, 1);
      // async reset while acknowledging
      #2 rst = 1;
      #1;
      chk("arst_ack", a_if.ack_out, 0);
      chk("arst_cnt", {c0_a, c1_a}, 0);
      chk("arst_err", pe_a, 0);
      chk("arst_busy", busy_a, 0);
      a_if.req_in = 0;
      step(2);
      rst = 0;
      step(1);
      chk("arst_hold", {a_if.ack_out, busy_a}, 0);
      // saturation with CNT_W=2
      for (int g = 0; g < 5; g++) begin
         b_if.req_in = 1;
         step(8);
         chk($sformatf("sat_ack_%0d", g), b_if.ack_out, 1);
         chk($sformatf("sat_cnt0_%0d", g), c0_b, sat_exp[g]);
         b_if.req_in = 0;
         step(4);
      end
      chk("sat_cnt1", c1_b, 0);
      // short service, deeper sync, sel toggled during ACK
      c_if.sel_in = 1; c_if.req_in = 1;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         chk($sformatf("fast_ack_e%0d", k), c_if.ack_out, k == 6);
      end
      chk("fast_id", gid_c, 1);
      c_if.sel_in = 0;
      step(4);
      chk("fast_id_held", gid_c, 1);
      chk("fast_ack_held", c_if.ack_out, 1);
      c_if.req_in = 0;
      step(5);
      chk("fast_rel", {c_if.ack_out, busy_c}, 0);
      chk("fast_cnts", {c0_c, c1_c}, {16'd0, 16'd1});
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
